// File: rtl/proc_stream_loader.sv
// proc_stream_loader
//   Host-side sequencer in front of top_processor. A single input stream is
//   written in order into the A data memory, B data memory and op memory
//   (N words each). It then holds start_o until the processor reports done,
//   and streams the output memory back out over a valid/ready interface.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   go_i, len_i         job request and job length N (1..DEPTH accepted)
//   busy_o              high whenever not idle
//   err_o               one-cycle pulse when a job request is rejected
//   done_o              one-cycle pulse after the last result handshake
//   s_data_i/s_valid_i/s_ready_o            input word stream
//   m_data_o/m_valid_o/m_ready_i/m_last_o   result word stream
//   data_o, addr_data_o                     A/B write data, A/B/out address
//   ena/wea_data_a_o, ena/wea_data_b_o      A and B memory strobes
//   ena/wea_data_o_o                        output memory strobes (read only)
//   op_o, addr_op_o, ena_op_o, wea_op_o     op memory write port
//   start_o, done_i                         processor handshake
//   rdata_i                                 output memory read data (1-cycle latency)

module proc_stream_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  go_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  output logic                  busy_o,
  output logic                  err_o,
  output logic                  done_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [ADDR_WIDTH-1:0] addr_data_o,
  output logic                  ena_data_a_o,
  output logic                  wea_data_a_o,
  output logic                  ena_data_b_o,
  output logic                  wea_data_b_o,
  output logic                  ena_data_o_o,
  output logic                  wea_data_o_o,
  output logic [OP_WIDTH-1:0]   op_o,
  output logic [ADDR_WIDTH-1:0] addr_op_o,
  output logic                  ena_op_o,
  output logic                  wea_op_o,
  output logic                  start_o,
  input  logic                  done_i,
  input  logic [DATA_WIDTH-1:0] rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_LOAD_OP,
    S_RUN,
    S_RD_REQ,
    S_RD_WAIT,
    S_SEND
  } state_t;

  localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] IDX_ONE = (ADDR_WIDTH + 1)'(1);

  state_t                state;
  // One bit wider than the address so that N = DEPTH is representable.
  logic [ADDR_WIDTH:0]   idx;
  logic [ADDR_WIDTH:0]   n_len;
  logic [ADDR_WIDTH:0]   idx_inc;
  logic                  idx_last;
  logic                  len_ok;
  logic                  beat;

  always_comb begin
    idx_inc  = idx + IDX_ONE;
    idx_last = (idx == n_len - IDX_ONE);
    len_ok   = (len_i != '0) && (len_i <= MAX_LEN);
    beat     = s_valid_i && s_ready_o;
  end

  // The output memory is never written from this side.
  assign wea_data_o_o = 1'b0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      idx          <= '0;
      n_len        <= '0;
      busy_o       <= 1'b0;
      err_o        <= 1'b0;
      done_o       <= 1'b0;
      s_ready_o    <= 1'b0;
      m_data_o     <= '0;
      m_valid_o    <= 1'b0;
      m_last_o     <= 1'b0;
      data_o       <= '0;
      addr_data_o  <= '0;
      ena_data_a_o <= 1'b0;
      wea_data_a_o <= 1'b0;
      ena_data_b_o <= 1'b0;
      wea_data_b_o <= 1'b0;
      ena_data_o_o <= 1'b0;
      op_o         <= '0;
      addr_op_o    <= '0;
      ena_op_o     <= 1'b0;
      wea_op_o     <= 1'b0;
      start_o      <= 1'b0;
    end else begin
      // Pulses and memory strobes last exactly one cycle unless re-armed below.
      err_o        <= 1'b0;
      done_o       <= 1'b0;
      ena_data_a_o <= 1'b0;
      wea_data_a_o <= 1'b0;
      ena_data_b_o <= 1'b0;
      wea_data_b_o <= 1'b0;
      ena_data_o_o <= 1'b0;
      ena_op_o     <= 1'b0;
      wea_op_o     <= 1'b0;

      case (state)
        S_IDLE: begin
          if (go_i) begin
            if (len_ok) begin
              n_len     <= len_i;
              idx       <= '0;
              state     <= S_LOAD_A;
              busy_o    <= 1'b1;
              s_ready_o <= 1'b1;
            end else begin
              err_o <= 1'b1;
            end
          end
        end

        S_LOAD_A: begin
          if (beat) begin
            ena_data_a_o <= 1'b1;
            wea_data_a_o <= 1'b1;
            addr_data_o  <= idx[ADDR_WIDTH-1:0];
            data_o       <= s_data_i;
            if (idx_last) begin
              idx   <= '0;
              state <= S_LOAD_B;
            end else begin
              idx <= idx_inc;
            end
          end
        end

        S_LOAD_B: begin
          if (beat) begin
            ena_data_b_o <= 1'b1;
            wea_data_b_o <= 1'b1;
            addr_data_o  <= idx[ADDR_WIDTH-1:0];
            data_o       <= s_data_i;
            if (idx_last) begin
              idx   <= '0;
              state <= S_LOAD_OP;
            end else begin
              idx <= idx_inc;
            end
          end
        end

        S_LOAD_OP: begin
          if (beat) begin
            ena_op_o  <= 1'b1;
            wea_op_o  <= 1'b1;
            addr_op_o <= idx[ADDR_WIDTH-1:0];
            op_o      <= s_data_i[OP_WIDTH-1:0];
            if (idx_last) begin
              idx       <= '0;
              state     <= S_RUN;
              s_ready_o <= 1'b0;
              start_o   <= 1'b1;
            end else begin
              idx <= idx_inc;
            end
          end
        end

        S_RUN: begin
          // The read request for word 0 is issued on the same edge that
          // drops start_o, so RD_REQ already drives the read strobe.
          if (done_i) begin
            start_o      <= 1'b0;
            idx          <= '0;
            state        <= S_RD_REQ;
            ena_data_o_o <= 1'b1;
            addr_data_o  <= '0;
          end
        end

        S_RD_REQ: begin
          state <= S_RD_WAIT;
        end

        S_RD_WAIT: begin
          m_data_o  <= rdata_i;
          m_valid_o <= 1'b1;
          m_last_o  <= idx_last;
          state     <= S_SEND;
        end

        S_SEND: begin
          if (m_ready_i) begin
            m_valid_o <= 1'b0;
            m_last_o  <= 1'b0;
            if (idx_last) begin
              done_o <= 1'b1;
              busy_o <= 1'b0;
              idx    <= '0;
              state  <= S_IDLE;
            end else begin
              idx          <= idx_inc;
              state        <= S_RD_REQ;
              ena_data_o_o <= 1'b1;
              addr_data_o  <= idx_inc[ADDR_WIDTH-1:0];
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
